instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on rising clk edge.
REQ-004 mux_ctrl  input  1  next-PC select: 0 = sequential (PC_4), 1 = jump (jp_address).
REQ-005 jp_address  input  4  jump target, word address into instruction memory.
REQ-006 instruction  output  32  instruction word stored at current PC.
REQ-007 PC_4  output  4  sequential successor of current PC, (PC + 1) mod 16.

Function
REQ-008 The block SHALL hold a 4-bit program-counter register PC, a word address (one address = one 32-bit instruction).
REQ-009 The block SHALL contain a read-only instruction memory of 16 words x 32 bits, addressed by PC.
REQ-010 ROM contents SHALL be fixed at elaboration: word i = 32'h2008_0000 + i, for i = 0..15 (e.g. word 0 = 32'h2008_0000, word 10 = 32'h2008_000A, word 15 = 32'h2008_000F).
REQ-011 instruction SHALL be a combinational read of ROM[PC]: valid in the same cycle PC changes, zero-cycle latency, no output register.
REQ-012 PC_4 SHALL be combinational: PC_4 = PC + 1, truncated to 4 bits (PC = 15 -> PC_4 = 0).
REQ-013 Next-PC mux: next_PC = jp_address when mux_ctrl = 1, else PC_4.
REQ-014 On each rising clk edge with reset = 0, PC SHALL load next_PC.
REQ-015 mux_ctrl and jp_address SHALL be sampled only at the rising edge; changes between edges SHALL not affect PC, only the combinational next_PC.
REQ-016 A jump SHALL take effect one edge after being sampled: instruction shows ROM[jp_address] immediately after that edge.
REQ-017 Sequential fetch SHALL wrap: PC = 15 with mux_ctrl = 0 -> PC = 0 on next edge.
REQ-018 Jump to current address (jp_address = PC, mux_ctrl = 1) SHALL hold PC constant; held mux_ctrl = 1 SHALL keep PC = jp_address every cycle.
REQ-019 Jump to any address 0..15 SHALL be legal, including 15 (then PC_4 = 0).
REQ-020 No X SHALL propagate from ROM: every address 0..15 is populated.

Reset
REQ-021 reset = 1 at a rising edge SHALL set PC = 0, overriding mux_ctrl and jp_address.
REQ-022 After reset: PC = 0, instruction = 32'h2008_0000, PC_4 = 4'h1.
REQ-023 Reset asserted mid-sequence or in the same cycle as a jump SHALL force PC = 0 on that edge; the jump is discarded.
REQ-024 First edge with reset = 0 SHALL resume normal next_PC loading from PC = 0.
REQ-025 Before the first reset, PC contents are undefined; the bench SHALL apply reset before checking outputs.

Verification
REQ-026 Reset 1 cycle, then mux_ctrl = 0, jp_address = 4'hA for 5 edges -> PC 1,2,3,4,5; instruction 32'h2008_0001..32'h2008_0005; PC_4 one ahead each cycle.
REQ-027 From PC = 3, mux_ctrl = 1, jp_address = 4'hA for one edge, then mux_ctrl = 0 -> PC = 10 (instruction 32'h2008_000A, PC_4 = 4'hB), then PC = 11.
REQ-028 Sequential run to PC = 15 -> instruction 32'h2008_000F, PC_4 = 4'h0; next edge PC = 0, instruction 32'h2008_0000.
REQ-029 mux_ctrl = 1 held, jp_address = 4'h7 for 3 edges -> PC = 7 every cycle, PC_4 = 4'h8.
REQ-030 At PC = 6, reset = 1 together with mux_ctrl = 1, jp_address = 4'hC -> PC = 0 after edge; release reset with mux_ctrl = 0 -> PC = 1.
REQ-031 jp_address/mux_ctrl toggled between edges then restored before edge -> PC unaffected, follows value sampled at edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: next-PC control in from the core, instruction and PC+1 back out.
interface instruction_fetch_if;
    logic        mux_ctrl;
    logic [3:0]  jp_address;
    logic [31:0] instruction;
    logic [3:0]  PC_4;

    // master drives next-PC control and consumes the fetched word
    modport master (
        output mux_ctrl,
        output jp_address,
        input  instruction,
        input  PC_4
    );

    modport slave (
        input  mux_ctrl,
        input  jp_address,
        output instruction,
        output PC_4
    );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter with a 16-word fixed instruction ROM; combinational fetch and PC+1,
// next PC chosen between sequential successor and jump target.
module instruction_fetch (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.slave   bus
);
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROM_DEPTH = 16;
    localparam logic [DATA_W-1:0] ROM_BASE = 32'h2008_0000;

    typedef logic [DATA_W-1:0] rom_t [ROM_DEPTH];

    // Every word is populated so a fetch can never return X.
    function automatic rom_t init_rom();
        rom_t r;
        for (int i = 0; i < int'(ROM_DEPTH); i++) begin
            r[i] = ROM_BASE + DATA_W'(i);
        end
        return r;
    endfunction

    localparam rom_t ROM = init_rom();

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        pc_plus1 = ADDR_W'(pc + ADDR_W'(1));
        next_pc  = bus.mux_ctrl ? bus.jp_address : pc_plus1;
    end

    // Reset wins over any jump presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end

    assign bus.instruction = ROM[pc];
    assign bus.PC_4        = pc_plus1;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, jumps, wrap, reset priority,
// and insensitivity to input glitches between clock edges.
module tb_instruction_fetch;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic rst, input logic mux, input logic [3:0] jp);
        reset          = rst;
        bus.mux_ctrl   = mux;
        bus.jp_address = jp;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_instr, input logic [3:0] exp_pc4);
        checks++;
        assert (bus.instruction === exp_instr) else begin
            failures++;
            $error("FAIL %s instruction: observed=%h expected=%h", tag, bus.instruction, exp_instr);
        end
        checks++;
        assert (bus.PC_4 === exp_pc4) else begin
            failures++;
            $error("FAIL %s PC_4: observed=%h expected=%h", tag, bus.PC_4, exp_pc4);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus.mux_ctrl   = 1'b0;
        bus.jp_address = 4'h0;

        apply(1'b1, 1'b0, 4'h0);
        check("reset", 32'h2008_0000, 4'h1);

        // Sequential run with an unselected jump target present
        apply(1'b0, 1'b0, 4'hA); check("seq1", 32'h2008_0001, 4'h2);
        apply(1'b0, 1'b0, 4'hA); check("seq2", 32'h2008_0002, 4'h3);
        apply(1'b0, 1'b0, 4'hA); check("seq3", 32'h2008_0003, 4'h4);
        apply(1'b0, 1'b0, 4'hA); check("seq4", 32'h2008_0004, 4'h5);
        apply(1'b0, 1'b0, 4'hA); check("seq5", 32'h2008_0005, 4'h6);

        // Back to 0, walk to 3, then a single-cycle jump to 10
        apply(1'b1, 1'b0, 4'h0); check("reset2", 32'h2008_0000, 4'h1);
        apply(1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 4'h0); check("pc3", 32'h2008_0003, 4'h4);
        apply(1'b0, 1'b1, 4'hA); check("jump_a", 32'h2008_000A, 4'hB);
        apply(1'b0, 1'b0, 4'hA); check("after_jump", 32'h2008_000B, 4'hC);

        // Run to 15 and wrap
        apply(1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 4'h0); check("pc15", 32'h2008_000F, 4'h0);
        apply(1'b0, 1'b0, 4'h0); check("wrap", 32'h2008_0000, 4'h1);

        // Held jump to 7 pins the PC
        apply(1'b0, 1'b1, 4'h7); check("hold7_1", 32'h2008_0007, 4'h8);
        apply(1'b0, 1'b1, 4'h7); check("hold7_2", 32'h2008_0007, 4'h8);
        apply(1'b0, 1'b1, 4'h7); check("hold7_3", 32'h2008_0007, 4'h8);

        // Jump to the top address
        apply(1'b0, 1'b1, 4'hF); check("jump_f", 32'h2008_000F, 4'h0);

        // Reset collides with a jump at PC 6
        apply(1'b0, 1'b1, 4'h6); check("jump_6", 32'h2008_0006, 4'h7);
        apply(1'b1, 1'b1, 4'hC); check("reset_vs_jump", 32'h2008_0000, 4'h1);
        apply(1'b0, 1'b0, 4'hC); check("release", 32'h2008_0001, 4'h2);

        // Glitch inputs between edges, restore to sequential before the edge
        #1; bus.mux_ctrl = 1'b1; bus.jp_address = 4'h3;
        #2; bus.jp_address = 4'hD;
        check("mid_cycle_hold", 32'h2008_0001, 4'h2);
        #2; bus.mux_ctrl = 1'b0; bus.jp_address = 4'hA;
        @(posedge clk); #1;
        check("glitch_seq", 32'h2008_0002, 4'h3);

        // Glitch toward sequential, settle on a jump to 9 before the edge
        #1; bus.mux_ctrl = 1'b0; bus.jp_address = 4'h4;
        #2; bus.mux_ctrl = 1'b1; bus.jp_address = 4'h9;
        @(posedge clk); #1;
        check("glitch_jump", 32'h2008_0009, 4'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
